// File: rtl/aq_ram25_axis_reader.sv
// rtl/aq_ram25_axis_reader.sv - RAM read-side drain engine presenting words as an AXI4-Stream master
`timescale 1ns/1ps
module aq_ram25_axis_reader #(
    parameter int DATA_W = 25,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [LEN_W-1:0]  issue_cnt;
    logic [LEN_W-1:0]  beat_cnt;
    logic              in_flight;

    // Two-entry output buffer; the head entry drives the stream.
    logic [DATA_W-1:0] buf0;
    logic [DATA_W-1:0] buf1;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        occ;

    logic              pop;
    logic              push;
    logic [2:0]        occ_sum;
    logic              issue;
    logic              job_go;
    logic              last_hs;

    // Issue decisions: a read is only launched if its word is guaranteed a buffer slot
    // once it returns, counting the word already in the RAM pipe and this cycle's pop.
    always_comb begin
        pop     = (occ != 2'd0) && m_axis_tready;
        push    = in_flight;
        occ_sum = {1'b0, occ} + {2'b00, in_flight} - {2'b00, pop};
        issue   = (state == ST_READ) && (issue_cnt != '0) && (occ_sum < 3'd2);
        job_go  = (state == ST_IDLE) && start && (length != '0);
        last_hs = pop && (beat_cnt == LEN_W'(1));
    end

    // Job sequencing: IDLE -> READ -> DRAIN -> FIN -> IDLE, empty jobs go straight to FIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= (length != '0) ? ST_READ : ST_FIN;
                    end
                end
                ST_READ: begin
                    if (issue && (issue_cnt == LEN_W'(1))) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (last_hs) begin
                        state <= ST_FIN;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read address and the two job counters (reads still to issue, beats still to deliver).
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr_q <= '0;
            issue_cnt  <= '0;
            beat_cnt   <= '0;
        end else if (job_go) begin
            ram_addr_q <= base_addr;
            issue_cnt  <= length;
            beat_cnt   <= length;
        end else begin
            if (issue) begin
                ram_addr_q <= ram_addr_q + ADDR_W'(1);
                issue_cnt  <= issue_cnt - LEN_W'(1);
            end
            if (pop) begin
                beat_cnt <= beat_cnt - LEN_W'(1);
            end
        end
    end

    // Tracks the one-cycle RAM read latency: a word issued now arrives next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight <= 1'b0;
        end else begin
            in_flight <= issue;
        end
    end

    // Output FIFO: returning RAM words are written at the tail, the stream pops the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf0   <= '0;
            buf1   <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr) begin
                    buf1 <= ram_dout;
                end else begin
                    buf0 <= ram_dout;
                end
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Outputs are decoded purely from registered state, so TVALID never follows TREADY.
    always_comb begin
        ram_addr      = ram_addr_q;
        m_axis_tvalid = (occ != 2'd0);
        m_axis_tdata  = rd_ptr ? buf1 : buf0;
        m_axis_tlast  = (occ != 2'd0) && (beat_cnt == LEN_W'(1));
        busy          = (state == ST_READ) || (state == ST_DRAIN);
        done          = (state == ST_FIN);
    end

endmodule
